// File: rtl/avst_pkt_gen_if.sv
// Avalon-ST beat channel between the packet generator (master) and its sink (slave).
interface avst_pkt_gen_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   ready;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avst_pkt_gen.sv
// Avalon-ST packet source: multi-packet runs with fixed or LFSR-random lengths,
// programmable gaps and a recomputable payload (byte k of packet p = p + k).
module avst_pkt_gen #(
  parameter int          DATA_WIDTH  = 512,
  parameter int          EMPTY_WIDTH = 6,
  parameter int          LEN_WIDTH   = 16,
  parameter logic [31:0] SEED        = 32'h2022_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [15:0]          cfg_num_pkts_i,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 cfg_rand_len_i,
  input  logic [7:0]           cfg_gap_i,
  avst_pkt_gen_if.master       src,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          pkt_count_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LW1   = LEN_WIDTH + 1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1, right-shifting Galois

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_e;

  state_e                 state_q;
  logic [31:0]            lfsr_q;
  logic [15:0]            num_pkts_q;
  logic [LEN_WIDTH-1:0]   cfg_len_q;
  logic                   rand_q;
  logic [7:0]             gap_q;
  logic [7:0]             gap_cnt_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beats_q;
  logic [EMPTY_WIDTH-1:0] eop_empty_q;
  logic [LEN_WIDTH-1:0]   beat_idx_q;
  logic [LEN_WIDTH-1:0]   byte_off_q;
  logic [15:0]            pkt_count_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   valid_q, sop_q, eop_q, busy_q, done_q;
  logic [EMPTY_WIDTH-1:0] empty_q;

  logic [31:0]            lfsr_d;
  logic [LEN_WIDTH-1:0]   len_d;
  logic [LW1-1:0]         beats_sum_d;
  logic [LEN_WIDTH-1:0]   beats_d;
  logic [LEN_WIDTH-1:0]   rem_d;
  logic [EMPTY_WIDTH-1:0] eop_empty_d;
  logic [LEN_WIDTH-1:0]   next_idx_d;
  logic [LEN_WIDTH-1:0]   next_off_d;
  logic                   next_eop_d;
  logic                   last_pkt_d;
  logic                   accept;

  // Bytes at or beyond len are zero; k is one bit wider so off+i cannot wrap.
  function automatic logic [DATA_WIDTH-1:0] build_beat(input logic [7:0]           pkt,
                                                       input logic [LEN_WIDTH-1:0] off,
                                                       input logic [LEN_WIDTH-1:0] len);
    logic [LW1-1:0] k;
    build_beat = '0;
    for (int i = 0; i < BYTES; i++) begin
      k = {1'b0, off} + LW1'(i);
      if (k < {1'b0, len}) build_beat[DATA_WIDTH-1-8*i -: 8] = pkt + k[7:0];
    end
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    len_d       = rand_q ? (lfsr_q[LEN_WIDTH-1:0] % cfg_len_q) + LEN_WIDTH'(1) : cfg_len_q;
    beats_sum_d = {1'b0, len_d} + LW1'(BYTES - 1);
    beats_d     = LEN_WIDTH'(beats_sum_d / LW1'(BYTES));
    rem_d       = len_d % LEN_WIDTH'(BYTES);
    eop_empty_d = (rem_d == '0) ? '0 : EMPTY_WIDTH'(LEN_WIDTH'(BYTES) - rem_d);
    next_idx_d  = beat_idx_q + LEN_WIDTH'(1);
    next_off_d  = byte_off_q + LEN_WIDTH'(BYTES);
    next_eop_d  = (next_idx_d == beats_q - LEN_WIDTH'(1));
    last_pkt_d  = ((pkt_count_q + 16'd1) == num_pkts_q);
    accept      = valid_q && src.ready;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      num_pkts_q  <= '0;
      cfg_len_q   <= LEN_WIDTH'(1);
      rand_q      <= 1'b0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      eop_empty_q <= '0;
      beat_idx_q  <= '0;
      byte_off_q  <= '0;
      pkt_count_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            num_pkts_q  <= cfg_num_pkts_i;
            cfg_len_q   <= (cfg_len_i == '0) ? LEN_WIDTH'(1) : cfg_len_i;
            rand_q      <= cfg_rand_len_i;
            gap_q       <= cfg_gap_i;
            pkt_count_q <= '0;
            busy_q      <= 1'b1;
            if (cfg_num_pkts_i != '0) begin
              state_q <= LOAD;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          len_q       <= len_d;
          beats_q     <= beats_d;
          eop_empty_q <= eop_empty_d;
          lfsr_q      <= lfsr_d;
          beat_idx_q  <= '0;
          byte_off_q  <= '0;
          data_q      <= build_beat(pkt_count_q[7:0], '0, len_d);
          valid_q     <= 1'b1;
          sop_q       <= 1'b1;
          eop_q       <= (beats_d == LEN_WIDTH'(1));
          empty_q     <= (beats_d == LEN_WIDTH'(1)) ? eop_empty_d : '0;
          state_q     <= SEND;
        end
        SEND: begin
          // Registers hold their value while stalled, keeping the beat stable.
          if (accept) begin
            if (eop_q) begin
              valid_q     <= 1'b0;
              sop_q       <= 1'b0;
              eop_q       <= 1'b0;
              empty_q     <= '0;
              data_q      <= '0;
              pkt_count_q <= pkt_count_q + 16'd1;
              if (last_pkt_d) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else if (gap_q != '0) begin
                state_q   <= GAP;
                gap_cnt_q <= gap_q;
              end else begin
                state_q <= LOAD;
              end
            end else begin
              beat_idx_q <= next_idx_d;
              byte_off_q <= next_off_d;
              data_q     <= build_beat(pkt_count_q[7:0], next_off_d, len_q);
              sop_q      <= 1'b0;
              eop_q      <= next_eop_d;
              empty_q    <= next_eop_d ? eop_empty_q : '0;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 8'd1) state_q <= LOAD;
          else                   gap_cnt_q <= gap_cnt_q - 8'd1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src.data    = data_q;
  assign src.valid   = valid_q;
  assign src.sop     = sop_q;
  assign src.eop     = eop_q;
  assign src.empty   = empty_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_avst_pkt_gen.sv
// Scoreboard bench for avst_pkt_gen: directed runs push expected beats, a negedge
// monitor pops and compares every accepted beat plus stall, spacing and latency rules.
module tb_avst_pkt_gen;

  localparam int          DW    = 512;
  localparam int          EW    = 6;
  localparam int          LW    = 16;
  localparam int          BYTES = DW / 8;
  localparam logic [31:0] SEED  = 32'h2022_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   cfg_num_pkts = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_rand_len = 1'b0;
  logic [7:0]    cfg_gap = '0;
  logic          busy, done;
  logic [15:0]   pkt_count;

  avst_pkt_gen_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) bus ();

  avst_pkt_gen #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .LEN_WIDTH(LW), .SEED(SEED)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .cfg_num_pkts_i (cfg_num_pkts),
    .cfg_len_i      (cfg_len),
    .cfg_rand_len_i (cfg_rand_len),
    .cfg_gap_i      (cfg_gap),
    .src            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .pkt_count_o    (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    int            pkt;
    int            gap;
    bit            last;
  } beat_t;

  beat_t       exp_q[$];
  int          obs_lens[$];
  int          lens_a[$];
  int          lens_b[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] m_lfsr = SEED;
  bit          ready_mode = 1'b0;
  bit          mon_en = 1'b0;
  bit          rec_len = 1'b0;

  // Monitor-private state
  beat_t         e;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [EW+1:0] prev_ctl;
  bit            gap_armed = 1'b0;
  bit            done_armed = 1'b0;
  bit            first_armed = 1'b0;
  int            eop_cyc = 0;
  int            gap_val = 0;
  int            pkt_beats = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) begin
      s[31] = ~s[31];
      s[21] = ~s[21];
      s[1]  = ~s[1];
      s[0]  = ~s[0];
    end
    return s;
  endfunction

  task automatic push_pkt(input int p, input int l, input int gap, input bit last);
    int    nb;
    int    k;
    beat_t b;
    nb = (l + BYTES - 1) / BYTES;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      for (int i = 0; i < BYTES; i++) begin
        k = bi * BYTES + i;
        b.data = {b.data[DW-9:0], (k < l) ? 8'((p + k) % 256) : 8'h00};
      end
      b.sop   = (bi == 0);
      b.eop   = (bi == nb - 1);
      b.empty = (bi == nb - 1) ? EW'(nb * BYTES - l) : '0;
      b.pkt   = p;
      b.gap   = gap;
      b.last  = last && (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic prepare_run(input int num, input int len, input bit rnd, input int gap);
    int len_eff;
    int l;
    len_eff = (len == 0) ? 1 : len;
    for (int p = 0; p < num; p++) begin
      l = rnd ? (int'(m_lfsr[15:0]) % len_eff) + 1 : len_eff;
      m_lfsr = lfsr_next(m_lfsr);
      push_pkt(p, l, gap, p == num - 1);
    end
  endtask

  task automatic pulse_start(input int num, input int len, input bit rnd, input int gap);
    @(negedge clk);
    cfg_num_pkts = 16'(num);
    cfg_len      = LW'(len);
    cfg_rand_len = rnd;
    cfg_gap      = 8'(gap);
    start        = 1'b1;
    start_cyc    = cyc;
    first_armed  = (num != 0);
  endtask

  // Deasserts start on the first negedge, then waits (bounded) for done.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected done within 5000 cycles", name);
    end
  endtask

  task automatic run(input string name, input int num, input int len, input bit rnd,
                     input int gap, input bit rmode, input bit poke);
    ready_mode = rmode;
    prepare_run(num, len, rnd, gap);
    pulse_start(num, len, rnd, gap);
    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        start = 1'b0;
      end
      start = 1'b1;  // issued while busy, must be ignored
    end
    wait_done(name);
    @(negedge clk);
    check({name, "_busy_after"}, busy, 1'b0);
    check({name, "_pkt_count"}, pkt_count, 16'(num));
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n       = 1'b0;
    start       = 1'b0;
    exp_q.delete();
    m_lfsr      = SEED;
    stall_prev  = 1'b0;
    gap_armed   = 1'b0;
    done_armed  = 1'b0;
    first_armed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) cyc++;

  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 bus.ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (stall_prev) begin
        check("stall_valid", bus.valid, 1'b1);
        check("stall_data", bus.data, prev_data);
        check("stall_ctl", {bus.sop, bus.eop, bus.empty}, prev_ctl);
      end
      if (first_armed && bus.valid) begin
        check("start_latency", cyc - start_cyc, 2);
        first_armed = 1'b0;
      end
      if (gap_armed && bus.valid) begin
        check("sop_spacing", cyc - eop_cyc, 2 + gap_val);
        gap_armed = 1'b0;
      end
      if (done_armed && done) begin
        check("done_latency", cyc - eop_cyc, 1);
        done_armed = 1'b0;
      end
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got beat sop=%0b eop=%0b, expected no beat", bus.sop, bus.eop);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.data, e.data);
          check("beat_sop", bus.sop, e.sop);
          check("beat_eop", bus.eop, e.eop);
          check("beat_empty", bus.empty, e.empty);
          check("beat_pkt_count", pkt_count, 16'(e.pkt));
          pkt_beats = bus.sop ? 1 : pkt_beats + 1;
          if (bus.eop) begin
            if (rec_len) obs_lens.push_back(pkt_beats * BYTES - int'(bus.empty));
            eop_cyc = cyc;
            if (e.last) done_armed = 1'b1;
            else begin
              gap_armed = 1'b1;
              gap_val   = e.gap;
            end
          end
        end
      end
      stall_prev = bus.valid && !bus.ready;
      prev_data  = bus.data;
      prev_ctl   = {bus.sop, bus.eop, bus.empty};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected bench to finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, sampled while reset is held
    repeat (2) @(negedge clk);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_sop", bus.sop, 1'b0);
    check("rst_eop", bus.eop, 1'b0);
    check("rst_data", bus.data, '0);
    check("rst_empty", bus.empty, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pkt_count", pkt_count, '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run("single64", 1, 64, 1'b0, 0, 1'b0, 1'b0);
    run("two130", 2, 130, 1'b0, 0, 1'b0, 1'b0);
    run("stall200", 4, 200, 1'b0, 1, 1'b1, 1'b0);
    run("gap3", 3, 10, 1'b0, 3, 1'b0, 1'b1);

    // Zero packets: done right after start, then a start in the DONE cycle is ignored
    ready_mode = 1'b0;
    pulse_start(0, 10, 1'b0, 0);
    wait_done("zero");
    check("zero_done_latency", done_cyc - start_cyc, 1);
    cfg_num_pkts = 16'd1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy_after", busy, 1'b0);
    repeat (8) @(negedge clk);
    check("zero_start_in_done_ignored", busy, 1'b0);
    check("zero_valid_low", bus.valid, 1'b0);

    // Random lengths, twice from reset: sequences must repeat and stay in range
    reset_dut();
    obs_lens.delete();
    rec_len = 1'b1;
    run("randA", 50, 300, 1'b1, 0, 1'b0, 1'b0);
    lens_a = obs_lens;
    reset_dut();
    obs_lens.delete();
    run("randB", 50, 300, 1'b1, 0, 1'b1, 1'b0);
    lens_b = obs_lens;
    rec_len = 1'b0;
    check("randA_count", lens_a.size(), 50);
    check("randB_count", lens_b.size(), 50);
    for (int i = 0; i < lens_a.size() && i < lens_b.size(); i++) begin
      check("rand_len_in_range", (lens_a[i] >= 1) && (lens_a[i] <= 300), 1'b1);
      check("rand_len_repeat", lens_b[i], lens_a[i]);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset mid-packet: outputs drop immediately, nothing further is emitted
    ready_mode = 1'b0;
    prepare_run(1, 200, 1'b0, 0);
    pulse_start(1, 200, 1'b0, 0);
    for (int i = 0; i < 20 && !(bus.valid && !bus.sop); i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_reached_beat1", bus.valid && !bus.sop, 1'b1);
    mon_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.valid, 1'b0);
    check("midrst_sop", bus.sop, 1'b0);
    check("midrst_eop", bus.eop, 1'b0);
    check("midrst_data", bus.data, '0);
    check("midrst_empty", bus.empty, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_pkt_count", pkt_count, '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_stays_idle", {bus.valid, busy}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
